// File: rtl/i2c_tof_pkg.sv
// Shared types and constants for the ToF-sensor I2C target model.
package i2c_tof_pkg;

  localparam int I2C_ADDR_BITS  = 7;
  localparam int REG_ADDR_BYTES = 2;
  localparam logic [I2C_ADDR_BITS-1:0] TOF_DEFAULT_ADDR = 7'h29;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_REGH,
    ST_REGH_ACK,
    ST_REGL,
    ST_REGL_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK
  } state_e;

endpackage

// File: rtl/i2c_tof_bus_cond.sv
// SCL/SDA synchronisers, edge history and START/STOP detection.
module i2c_tof_bus_cond (
  input  logic clk,
  input  logic reset,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_hist_q, sda_hist_q;
  logic       scl_s;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchroniser chain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
      scl_hist_q <= scl_sync_q[1];
      sda_hist_q <= sda_sync_q[1];
    end
  end

  assign scl_s     = scl_sync_q[1];
  assign sda_s     = sda_sync_q[1];
  assign scl_rise  = scl_s & ~scl_hist_q;
  assign scl_fall  = ~scl_s & scl_hist_q;
  // SCL must be high on both samples so an SCL edge is never mistaken for START/STOP.
  assign start_det = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
  assign stop_det  = scl_s & scl_hist_q & ~sda_hist_q & sda_s;

endmodule

// File: rtl/i2c_tof_target.sv
// I2C target modelling a ToF sensor register map (16-bit register pointer, auto-increment).
// Optional data-ready pin int_n is enabled by defining I2C_TOF_TARGET_INT_EN.
module i2c_tof_target
  import i2c_tof_pkg::*;
#(
  parameter logic [I2C_ADDR_BITS-1:0] SLAVE_ADDR   = TOF_DEFAULT_ADDR,
  parameter int                       MEM_AW       = 8,
  parameter logic [7:0]               OOR_READ_VAL = 8'hFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_o,
  output logic              sda_t,
  input  logic              host_we,
  input  logic [MEM_AW-1:0] host_addr,
  input  logic [7:0]        host_wdata,
  output logic [7:0]        host_rdata,
  output logic              wr_strobe,
  output logic [15:0]       wr_addr,
  output logic [7:0]        wr_data,
`ifdef I2C_TOF_TARGET_INT_EN
  output logic              int_n,
`endif
  output logic              busy
);

  localparam int PTR_W = 8 * REG_ADDR_BYTES;

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_tof_bus_cond u_bus_cond (
    .clk      (clk),
    .reset    (reset),
    .scl_i    (scl_i),
    .sda_i    (sda_i),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start_det(start_det),
    .stop_det (stop_det),
    .sda_s    (sda_s)
  );

  state_e             state_q, state_d;
  logic [3:0]         bit_cnt_q, bit_cnt_d;
  logic [7:0]         rx_q, rx_d, tx_q, tx_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d, ptr_inc;
  logic               sda_t_q, sda_t_d, busy_q, busy_d;
  logic               rw_q, rw_d, ack_q, ack_d;
  logic               wr_strobe_q, wr_strobe_d;
  logic [15:0]        wr_addr_q, wr_addr_d;
  logic [7:0]         wr_data_q, wr_data_d, host_rdata_q;
  logic [7:0]         rd_cur, rd_next;
  logic               mem_we;
  logic [7:0]         mem_q [2**MEM_AW];

  function automatic logic in_range(input logic [PTR_W-1:0] p);
    return (p >> MEM_AW) == '0;
  endfunction

  assign ptr_inc = ptr_q + 16'd1;
  assign rd_cur  = in_range(ptr_q)   ? mem_q[ptr_q[MEM_AW-1:0]]   : OOR_READ_VAL;
  assign rd_next = in_range(ptr_inc) ? mem_q[ptr_inc[MEM_AW-1:0]] : OOR_READ_VAL;

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    ptr_d       = ptr_q;
    sda_t_d     = sda_t_q;
    busy_d      = busy_q;
    rw_d        = rw_q;
    ack_d       = ack_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    mem_we      = 1'b0;

    if (stop_det) begin
      state_d = ST_IDLE;
      busy_d  = 1'b0;
      sda_t_d = 1'b1;
    end else if (start_det) begin
      // Repeated START keeps the pointer for write-address-then-read.
      state_d   = ST_ADDR;
      bit_cnt_d = 4'd0;
      sda_t_d   = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_ADDR, ST_REGH, ST_REGL, ST_WDATA: begin
          if (scl_rise && bit_cnt_q != 4'd8) begin
            rx_d      = {rx_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            bit_cnt_d = 4'd0;
            sda_t_d   = 1'b0;
            case (state_q)
              ST_ADDR: begin
                if (rx_q[7:1] == SLAVE_ADDR) begin
                  state_d = ST_ADDR_ACK;
                  busy_d  = 1'b1;
                  rw_d    = rx_q[0];
                end else begin
                  state_d = ST_IDLE;
                  busy_d  = 1'b0;
                  sda_t_d = 1'b1;
                end
              end
              ST_REGH: begin
                state_d = ST_REGH_ACK;
                ptr_d   = {rx_q, ptr_q[7:0]};
              end
              ST_REGL: begin
                state_d = ST_REGL_ACK;
                ptr_d   = {ptr_q[15:8], rx_q};
              end
              default: begin
                state_d     = ST_WDATA_ACK;
                mem_we      = in_range(ptr_q);
                wr_strobe_d = 1'b1;
                wr_addr_d   = ptr_q;
                wr_data_d   = rx_q;
                ptr_d       = ptr_inc;
              end
            endcase
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_d = 4'd0;
            if (rw_q) begin
              state_d = ST_RDATA;
              tx_d    = rd_cur;
              sda_t_d = rd_cur[7];
            end else begin
              state_d = ST_REGH;
              sda_t_d = 1'b1;
            end
          end
        end
        ST_REGH_ACK, ST_REGL_ACK, ST_WDATA_ACK: begin
          if (scl_fall) begin
            state_d = (state_q == ST_REGH_ACK) ? ST_REGL : ST_WDATA;
            sda_t_d = 1'b1;
          end
        end
        ST_RDATA: begin
          if (scl_rise && bit_cnt_q != 4'd8) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              state_d = ST_RDATA_ACK;
              sda_t_d = 1'b1;
            end else begin
              tx_d    = {tx_q[6:0], 1'b0};
              sda_t_d = tx_q[6];
            end
          end
        end
        ST_RDATA_ACK: begin
          if (scl_rise) begin
            ack_d = sda_s;
          end else if (scl_fall) begin
            if (!ack_q) begin
              state_d   = ST_RDATA;
              ptr_d     = ptr_inc;
              bit_cnt_d = 4'd0;
              tx_d      = rd_next;
              sda_t_d   = rd_next[7];
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= 4'd0;
      rx_q         <= 8'd0;
      tx_q         <= 8'd0;
      ptr_q        <= '0;
      sda_t_q      <= 1'b1;
      busy_q       <= 1'b0;
      rw_q         <= 1'b0;
      ack_q        <= 1'b1;
      wr_strobe_q  <= 1'b0;
      wr_addr_q    <= 16'd0;
      wr_data_q    <= 8'd0;
      host_rdata_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      rx_q         <= rx_d;
      tx_q         <= tx_d;
      ptr_q        <= ptr_d;
      sda_t_q      <= sda_t_d;
      busy_q       <= busy_d;
      rw_q         <= rw_d;
      ack_q        <= ack_d;
      wr_strobe_q  <= wr_strobe_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      host_rdata_q <= mem_q[host_addr];
    end
  end

  // NOTE: the register file has no reset; contents survive reset and map to RAM.
  // The I2C write is last so it wins a same-address collision with the host.
  always_ff @(posedge clk) begin
    if (host_we) mem_q[host_addr] <= host_wdata;
    if (mem_we)  mem_q[ptr_q[MEM_AW-1:0]] <= rx_q;
  end

`ifdef I2C_TOF_TARGET_INT_EN
  logic int_n_q, int_n_d, int_rd_hit;

  assign int_rd_hit = (state_q == ST_RDATA) && scl_fall && (bit_cnt_q == 4'd8) &&
                      (ptr_q == '0) && !start_det && !stop_det;

  always_comb begin
    int_n_d = int_n_q;
    if (int_rd_hit) int_n_d = 1'b1;
    if (host_we && host_addr == '0) int_n_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) int_n_q <= 1'b1;
    else        int_n_q <= int_n_d;
  end

  assign int_n = int_n_q;
`endif

  assign sda_o      = 1'b0;
  assign sda_t      = sda_t_q;
  assign busy       = busy_q;
  assign wr_strobe  = wr_strobe_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign host_rdata = host_rdata_q;

endmodule

// File: tb/tb_i2c_tof_target.sv
// Scoreboard bench for i2c_tof_target: bit-banged I2C master, queued expected writes/reads.
module tb_i2c_tof_target;

  localparam int MEM_AW = 8;
  localparam int Q      = 100;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              scl = 1'b1;
  logic              sda_m = 1'b1;
  logic              sda_bus;
  logic              sda_o, sda_t;
  logic              host_we = 1'b0;
  logic [MEM_AW-1:0] host_addr = '0;
  logic [7:0]        host_wdata = '0;
  logic [7:0]        host_rdata;
  logic              wr_strobe;
  logic [15:0]       wr_addr;
  logic [7:0]        wr_data;
  logic              busy;
`ifdef I2C_TOF_TARGET_INT_EN
  logic              int_n;
`endif

  int checks = 0;
  int failures = 0;
  wr_t        exp_wr[$];
  logic [7:0] exp_rd[$];
  logic [7:0] rd_obs[$];

  always #5 clk = ~clk;
  assign sda_bus = sda_m & (sda_t | sda_o);

  i2c_tof_target dut (
    .clk       (clk),
    .reset     (reset),
    .scl_i     (scl),
    .sda_i     (sda_bus),
    .sda_o     (sda_o),
    .sda_t     (sda_t),
    .host_we   (host_we),
    .host_addr (host_addr),
    .host_wdata(host_wdata),
    .host_rdata(host_rdata),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
`ifdef I2C_TOF_TARGET_INT_EN
    .int_n     (int_n),
`endif
    .busy      (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compares DUT write strobes and read bytes against the queued expectations.
  initial forever begin : monitor
    wr_t        e;
    logic [7:0] r;
    @(negedge clk);
    if (wr_strobe) begin
      if (exp_wr.size() == 0) check("wr_unexpected", 32'(wr_strobe), 32'd0);
      else begin
        e = exp_wr.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(e.a));
        check("wr_data", 32'(wr_data), 32'(e.d));
      end
    end
    if (rd_obs.size() != 0) begin
      r = rd_obs.pop_front();
      if (exp_rd.size() == 0) check("rd_unexpected", 32'(r), 32'hFFFF_FFFF);
      else check("rd_byte", 32'(r), 32'(exp_rd.pop_front()));
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not reach the end, expected completion");
    $fatal(1);
  end

  task automatic host_wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    host_we = 1'b1; host_addr = a; host_wdata = d;
    @(negedge clk);
    host_we = 1'b0;
  endtask

  task automatic host_chk(input string name, input logic [7:0] a, input logic [7:0] exp);
    @(negedge clk);
    host_addr = a;
    @(negedge clk);
    check(name, 32'(host_rdata), 32'(exp));
  endtask

  task automatic bit_out(input logic b);
    scl = 1'b0;
    #Q sda_m = b;
    #Q scl = 1'b1;
    #(2*Q) scl = 1'b0;
  endtask

  task automatic bit_in(output logic b);
    scl = 1'b0; sda_m = 1'b1;
    #(2*Q) scl = 1'b1;
    #Q b = sda_bus;
    #Q scl = 1'b0;
  endtask

  task automatic i2c_start;
    sda_m = 1'b1;
    #Q scl = 1'b1;
    #Q sda_m = 1'b0;
    #Q scl = 1'b0;
    #Q;
  endtask

  task automatic i2c_stop;
    scl = 1'b0; sda_m = 1'b0;
    #Q scl = 1'b1;
    #Q sda_m = 1'b1;
    #(2*Q);
  endtask

  // Sends one byte and returns the ACK bit as seen on the bus (1 = ACKed).
  task automatic wr_byte(input logic [7:0] d, output logic acked);
    logic b;
    for (int i = 7; i >= 0; i--) bit_out(d[i]);
    bit_in(b);
    acked = ~b;
  endtask

  task automatic send(input string name, input logic [7:0] d, input logic exp_ack);
    logic acked;
    wr_byte(d, acked);
    check(name, 32'(acked), 32'(exp_ack));
  endtask

  task automatic rd_byte(input logic nack);
    logic [7:0] d;
    for (int i = 7; i >= 0; i--) bit_in(d[i]);
    rd_obs.push_back(d);
    bit_out(nack);
  endtask

  initial begin
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_sda_t", 32'(sda_t), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wr_strobe", 32'(wr_strobe), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_host_rdata", 32'(host_rdata), 32'd0);
`ifdef I2C_TOF_TARGET_INT_EN
    check("rst_int_n", 32'(int_n), 32'd1);
`endif
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // Plain write of two bytes at 0x0010.
    exp_wr.push_back('{16'h0010, 8'hAB});
    exp_wr.push_back('{16'h0011, 8'hCD});
    i2c_start;
    send("w1_addr_ack", 8'h52, 1'b1);
    check("w1_busy", 32'(busy), 32'd1);
    send("w1_regh_ack", 8'h00, 1'b1);
    send("w1_regl_ack", 8'h10, 1'b1);
    send("w1_d0_ack", 8'hAB, 1'b1);
    send("w1_d1_ack", 8'hCD, 1'b1);
    i2c_stop;
    check("w1_busy_after_stop", 32'(busy), 32'd0);
    host_chk("w1_mem10", 8'h10, 8'hAB);
    host_chk("w1_mem11", 8'h11, 8'hCD);

    // Host preload, then write-pointer / repeated START / read two bytes.
    host_wr(8'h20, 8'h12);
    host_wr(8'h21, 8'h34);
    exp_rd.push_back(8'h12);
    exp_rd.push_back(8'h34);
    i2c_start;
    send("r1_addrw_ack", 8'h52, 1'b1);
    send("r1_regh_ack", 8'h00, 1'b1);
    send("r1_regl_ack", 8'h20, 1'b1);
    i2c_start;
    send("r1_addrr_ack", 8'h53, 1'b1);
    rd_byte(1'b0);
    rd_byte(1'b1);
    check("r1_sda_released", 32'(sda_t), 32'd1);
    i2c_stop;
    check("r1_busy_after_stop", 32'(busy), 32'd0);

    // Foreign address: no ACK and busy never rises.
    i2c_start;
    send("nm_addr_nack", 8'h60, 1'b0);
    check("nm_busy", 32'(busy), 32'd0);
    i2c_stop;
    check("nm_busy_after_stop", 32'(busy), 32'd0);

    // Out-of-range read returns the fill byte; out-of-range write is strobed but not stored.
    host_wr(8'h00, 8'h3C);
    exp_rd.push_back(8'hFF);
    i2c_start;
    send("oor_addrw_ack", 8'h52, 1'b1);
    send("oor_regh_ack", 8'h01, 1'b1);
    send("oor_regl_ack", 8'h00, 1'b1);
    i2c_start;
    send("oor_addrr_ack", 8'h53, 1'b1);
    rd_byte(1'b1);
    i2c_stop;
    exp_wr.push_back('{16'h0100, 8'h77});
    i2c_start;
    send("oorw_addr_ack", 8'h52, 1'b1);
    send("oorw_regh_ack", 8'h01, 1'b1);
    send("oorw_regl_ack", 8'h00, 1'b1);
    send("oorw_d_ack", 8'h77, 1'b1);
    i2c_stop;
    host_chk("oor_mem00_kept", 8'h00, 8'h3C);

    // STOP in the middle of a data byte, then recovery with a fresh write.
    host_wr(8'h40, 8'h99);
    i2c_start;
    send("ab_addr_ack", 8'h52, 1'b1);
    send("ab_regh_ack", 8'h00, 1'b1);
    send("ab_regl_ack", 8'h40, 1'b1);
    for (int i = 0; i < 4; i++) bit_out(1'b1);
    i2c_stop;
    check("ab_busy", 32'(busy), 32'd0);
    exp_wr.push_back('{16'h0005, 8'h5A});
    i2c_start;
    send("rc_addr_ack", 8'h52, 1'b1);
    send("rc_regh_ack", 8'h00, 1'b1);
    send("rc_regl_ack", 8'h05, 1'b1);
    send("rc_d_ack", 8'h5A, 1'b1);
    i2c_stop;
    host_chk("rc_mem05", 8'h05, 8'h5A);
    host_chk("ab_mem40_kept", 8'h40, 8'h99);

    // Pointer wrap FFFF -> 0000.
    host_wr(8'hFF, 8'h66);
    exp_wr.push_back('{16'hFFFF, 8'h11});
    exp_wr.push_back('{16'h0000, 8'h22});
    i2c_start;
    send("wrap_addr_ack", 8'h52, 1'b1);
    send("wrap_regh_ack", 8'hFF, 1'b1);
    send("wrap_regl_ack", 8'hFF, 1'b1);
    send("wrap_d0_ack", 8'h11, 1'b1);
    send("wrap_d1_ack", 8'h22, 1'b1);
    i2c_stop;
    host_chk("wrap_mem00", 8'h00, 8'h22);
    host_chk("wrap_memff_kept", 8'hFF, 8'h66);

`ifdef I2C_TOF_TARGET_INT_EN
    host_wr(8'h00, 8'h44);
    @(negedge clk);
    check("int_host_set", 32'(int_n), 32'd0);
    exp_rd.push_back(8'h44);
    i2c_start;
    send("int_addrw_ack", 8'h52, 1'b1);
    send("int_regh_ack", 8'h00, 1'b1);
    send("int_regl_ack", 8'h00, 1'b1);
    i2c_start;
    send("int_addrr_ack", 8'h53, 1'b1);
    rd_byte(1'b1);
    i2c_stop;
    check("int_read_clear", 32'(int_n), 32'd1);
`endif

    // Reset while the target is holding ACK low must release SDA at once.
    i2c_start;
    for (int i = 7; i >= 0; i--) bit_out(i == 0 ? 1'b0 : ((8'h52 >> i) & 8'h01) != 0);
    #Q;
    check("mid_ack_driven", 32'(sda_t), 32'd0);
    reset = 1'b0;
    #1;
    check("mid_rst_sda_t", 32'(sda_t), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    #Q reset = 1'b1;
    sda_m = 1'b1;
    scl = 1'b1;
    #(4*Q);

    repeat (20) @(negedge clk);
    check("exp_wr_drained", 32'(exp_wr.size()), 32'd0);
    check("exp_rd_drained", 32'(exp_rd.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
